// File: rtl/queue_dispatcher.sv
// ---------------------------------------------------------------------------
// queue_dispatcher
//
// Purpose:
//   Request-side front end for the FP/EDF schedulers. Per-core memory
//   transactions are buffered in NUMBER_OF_QUEUES independent FIFOs. The
//   block publishes an `empty` vector to the scheduler. It pops the queue
//   named by `selection` into a single registered output stage, which
//   hands the transaction to the memory port.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clock edge where valid and ready are
//   both 1. On the input side, in_ready[i] depends only on registered state.
//   On the output side, once out_valid is 1 then out_valid, out_data and
//   out_queue hold stable until the cycle in which out_ready is 1.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous active-low reset
//   in_valid   in   [NQ]        per-queue push request
//   in_data    in   [NQ][DW]    per-queue payload
//   in_ready   out  [NQ]        per-queue space available (count != DEPTH)
//   empty      out  [NQ]        per-queue "holds no entries" flag
//   selection  in   [SW]        queue chosen by the scheduler
//   out_valid  out              output stage holds a transaction
//   out_data   out  [DW]        transaction payload
//   out_queue  out  [SW]        source queue of the transaction
//   out_ready  in               downstream accepts the transaction
// ---------------------------------------------------------------------------
module queue_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH            = 4,
    parameter int SELECTION_WIDTH  = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUMBER_OF_QUEUES-1:0]                  in_valid,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]  in_data,
    output logic [NUMBER_OF_QUEUES-1:0]                  in_ready,
    output logic [NUMBER_OF_QUEUES-1:0]                  empty,
    input  logic [SELECTION_WIDTH-1:0]                   selection,
    output logic                                         out_valid,
    output logic [DATA_WIDTH-1:0]                        out_data,
    output logic [SELECTION_WIDTH-1:0]                   out_queue,
    input  logic                                         out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]         FULL_CNT = CNT_W'(DEPTH);
    // One extra bit so the range check is a real comparison even when
    // NUMBER_OF_QUEUES is a power of two.
    localparam logic [SELECTION_WIDTH:0] NQ_EXT   = (SELECTION_WIDTH + 1)'(NUMBER_OF_QUEUES);

    logic [DATA_WIDTH-1:0] mem   [NUMBER_OF_QUEUES][DEPTH];
    logic [CNT_W-1:0]      count [NUMBER_OF_QUEUES];
    logic [PTR_W-1:0]      wptr  [NUMBER_OF_QUEUES];
    logic [PTR_W-1:0]      rptr  [NUMBER_OF_QUEUES];

    logic [NUMBER_OF_QUEUES-1:0] push;
    logic [NUMBER_OF_QUEUES-1:0] pop_vec;
    logic                        free;
    logic                        sel_nonempty;
    logic                        sel_in_range;
    logic                        pop;
    logic [DATA_WIDTH-1:0]       sel_data;

    // Status flags come from registered counts only. There is therefore no
    // combinational path from selection/out_ready to in_ready or empty.
    always_comb begin
        in_ready = '0;
        empty    = '0;
        push     = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            in_ready[i] = (count[i] != FULL_CNT);
            empty[i]    = (count[i] == '0);
            push[i]     = in_valid[i] && (count[i] != FULL_CNT);
        end
    end

    // Pop decision. An out-of-range selection matches no queue, so it can
    // never pop. The explicit range term documents that intent.
    always_comb begin
        sel_nonempty = 1'b0;
        sel_data     = '0;
        pop_vec      = '0;
        free         = !out_valid || out_ready;
        sel_in_range = ({1'b0, selection} < NQ_EXT);
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (selection == SELECTION_WIDTH'(i)) begin
                sel_nonempty = (count[i] != '0);
                sel_data     = mem[i][rptr[i]];
            end
        end
        pop = free && sel_in_range && sel_nonempty;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            pop_vec[i] = pop && (selection == SELECTION_WIDTH'(i));
        end
    end

    // Counts and pointers. A push and a pop on the same queue in the same
    // cycle leave the count unchanged. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                count[i] <= '0;
                wptr[i]  <= '0;
                rptr[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                if (push[i]) begin
                    wptr[i] <= wptr[i] + PTR_W'(1);
                end
                if (pop_vec[i]) begin
                    rptr[i] <= rptr[i] + PTR_W'(1);
                end
                case ({push[i], pop_vec[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Payload storage is not reset. An entry is readable only after its
    // push has incremented the count.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (push[i]) begin
                mem[i][wptr[i]] <= in_data[i];
            end
        end
    end

    // Single-register output stage. When the stage is free and nothing is
    // popped, it empties.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_queue <= '0;
        end else if (free) begin
            out_valid <= pop;
            if (pop) begin
                out_data  <= sel_data;
                out_queue <= selection;
            end
        end
    end

endmodule

// File: tb/tb_queue_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_queue_dispatcher
//
// Purpose:
//   Self-checking bench for queue_dispatcher. The main instance uses 4
//   queues. A second instance uses 3 queues and exercises the out-of-range
//   selection case. A reference model holds one SystemVerilog queue per
//   FIFO plus the contents of the output stage. Directed scenarios run
//   first, followed by a randomized phase that includes an asynchronous
//   reset pulse in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_queue_dispatcher;

    localparam int NQ    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // main instance signals
    logic [NQ-1:0]         in_valid;
    logic [NQ-1:0][DW-1:0] in_data;
    logic [NQ-1:0]         in_ready;
    logic [NQ-1:0]         empty;
    logic [SW-1:0]         selection;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic [SW-1:0]         out_queue;
    logic                  out_ready;

    // three-queue instance signals
    logic [2:0]            in_valid3;
    logic [2:0][DW-1:0]    in_data3;
    logic [2:0]            in_ready3;
    logic [2:0]            empty3;
    logic [1:0]            selection3;
    logic                  out_valid3;
    logic [DW-1:0]         out_data3;
    logic [1:0]            out_queue3;
    logic                  out_ready3;

    queue_dispatcher #(
        .NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SELECTION_WIDTH(SW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .empty(empty),
        .selection(selection),
        .out_valid(out_valid), .out_data(out_data), .out_queue(out_queue),
        .out_ready(out_ready)
    );

    queue_dispatcher #(
        .NUMBER_OF_QUEUES(3), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SELECTION_WIDTH(2)
    ) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3), .empty(empty3),
        .selection(selection3),
        .out_valid(out_valid3), .out_data(out_data3), .out_queue(out_queue3),
        .out_ready(out_ready3)
    );

    // scoreboard / reference model
    int tests  = 0;
    int failed = 0;
    logic [DW-1:0] exp_q [NQ][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_queue;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) exp_q[i].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_queue = '0;
    endtask

    task automatic check_model();
        logic [NQ-1:0] exp_empty;
        logic [NQ-1:0] exp_ready;
        for (int i = 0; i < NQ; i++) begin
            exp_empty[i] = (exp_q[i].size() == 0);
            exp_ready[i] = (exp_q[i].size() < DEPTH);
        end
        check("empty", 64'(empty), 64'(exp_empty));
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_data", 64'(out_data), 64'(m_data));
            check("out_queue", 64'(out_queue), 64'(m_queue));
        end
    endtask

    // Advance one clock. The task decides what the model does from the
    // inputs present before the edge, samples the DUT 1 ns after the edge,
    // and then compares.
    task automatic step();
        logic [NQ-1:0] do_push;
        logic          do_pop;
        logic          was_free;
        int            s;
        s        = int'(selection);
        was_free = !m_valid || out_ready;
        do_pop   = was_free && (exp_q[s].size() > 0);
        for (int i = 0; i < NQ; i++) begin
            do_push[i] = in_valid[i] && (exp_q[i].size() < DEPTH);
        end
        @(posedge clock);
        #1;
        if (was_free) begin
            m_valid = do_pop;
            if (do_pop) begin
                m_data  = exp_q[s].pop_front();
                m_queue = selection;
            end
        end
        for (int i = 0; i < NQ; i++) begin
            if (do_push[i]) exp_q[i].push_back(in_data[i]);
        end
        check_model();
    endtask

    task automatic push_one(input int q, input logic [DW-1:0] d);
        in_valid    = '0;
        in_valid[q] = 1'b1;
        in_data[q]  = d;
        step();
        in_valid    = '0;
    endtask

    logic [DW-1:0] fill_exp [4];

    initial begin
        reset      = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        selection  = '0;
        out_ready  = 1'b0;
        in_valid3  = '0;
        in_data3   = '0;
        selection3 = '0;
        out_ready3 = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_queue", 64'(out_queue), 64'(0));
        check("rst_empty", 64'(empty), 64'(4'b1111));
        check("rst_in_ready", 64'(in_ready), 64'(4'b1111));
        check("rst_empty3", 64'(empty3), 64'(3'b111));
        reset = 1'b1;

        // Reset release: idle with selection 0
        selection = 2'd0;
        out_ready = 1'b1;
        step();
        step();
        check("idle_out_valid", 64'(out_valid), 64'(0));

        // Single push into queue 2
        push_one(2, 32'hA0);
        check("single_empty", 64'(empty), 64'(4'b1011));
        selection = 2'd2;
        step();
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_data", 64'(out_data), 64'(32'hA0));
        check("single_queue", 64'(out_queue), 64'(2));
        step();
        check("single_empty_after", 64'(empty), 64'(4'b1111));
        check("single_valid_after", 64'(out_valid), 64'(0));

        // Fill/wrap on queue 0, with queue 1 (empty) selected meanwhile
        selection = 2'd1;
        for (int k = 1; k <= 4; k++) push_one(0, DW'(k));
        check("fill_in_ready0", 64'(in_ready[0]), 64'(0));
        selection = 2'd0;
        step();
        check("wrap_first", 64'(out_data), 64'(1));
        selection = 2'd1;
        push_one(0, 32'd5);
        selection = 2'd0;
        fill_exp[0] = 32'd2; fill_exp[1] = 32'd3; fill_exp[2] = 32'd4; fill_exp[3] = 32'd5;
        for (int k = 0; k < 4; k++) begin
            step();
            check("wrap_data", 64'(out_data), 64'(fill_exp[k]));
            check("wrap_queue", 64'(out_queue), 64'(0));
        end
        step();
        check("wrap_drained", 64'(out_valid), 64'(0));

        // Backpressure
        selection = 2'd1;
        out_ready = 1'b0;
        in_valid  = 4'b0101;
        in_data[0] = 32'h11;
        in_data[2] = 32'h33;
        step();
        push_one(0, 32'h22);
        selection = 2'd0;
        step();
        check("bp_first", 64'(out_data), 64'(32'h11));
        for (int k = 0; k < 3; k++) begin
            selection = SW'(k + 2);
            step();
            check("bp_hold_data", 64'(out_data), 64'(32'h11));
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_empty", 64'(empty), 64'(4'b1010));
        end
        selection = 2'd0;
        out_ready = 1'b1;
        step();
        check("bp_next", 64'(out_data), 64'(32'h22));
        selection = 2'd2;
        step();
        check("bp_q2", 64'(out_data), 64'(32'h33));
        selection = 2'd3;
        step();

        // Full queue: a pop at count=DEPTH with a refused push in the same cycle
        for (int k = 0; k < 4; k++) push_one(1, DW'(32'hB0 + k));
        check("full_in_ready1", 64'(in_ready[1]), 64'(0));
        in_valid    = 4'b0010;
        in_data[1]  = 32'hBF;
        selection   = 2'd1;
        step();
        in_valid    = '0;
        check("full_pop_data", 64'(out_data), 64'(32'hB0));
        check("full_in_ready_after", 64'(in_ready[1]), 64'(1));
        for (int k = 1; k < 4; k++) begin
            step();
            check("full_drain", 64'(out_data), 64'(32'hB0 + k));
        end
        step();
        check("full_refused_gone", 64'(out_valid), 64'(0));

        // Empty selection
        selection = 2'd3;
        step();
        step();
        check("empty_sel_valid", 64'(out_valid), 64'(0));

        // Out-of-range selection on the three-queue instance
        in_valid3   = 3'b001;
        in_data3[0] = 32'hC3;
        step();
        in_valid3   = '0;
        check("nq3_empty", 64'(empty3), 64'(3'b110));
        selection3 = 2'd3;
        out_ready3 = 1'b1;
        step();
        step();
        check("nq3_oor_valid", 64'(out_valid3), 64'(0));
        check("nq3_oor_empty", 64'(empty3), 64'(3'b110));
        check("nq3_oor_ready", 64'(in_ready3), 64'(3'b111));
        selection3 = 2'd0;
        step();
        check("nq3_pop_valid", 64'(out_valid3), 64'(1));
        check("nq3_pop_data", 64'(out_data3), 64'(32'hC3));
        check("nq3_pop_queue", 64'(out_queue3), 64'(0));
        selection3 = 2'd3;

        // Randomized traffic, with an asynchronous reset pulse partway through
        for (int n = 0; n < 400; n++) begin
            in_valid  = NQ'($urandom_range(0, 15));
            for (int i = 0; i < NQ; i++) in_data[i] = $urandom;
            selection = SW'($urandom_range(0, NQ - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (n == 200) begin
                reset = 1'b0;
                #1;
                check("async_rst_valid", 64'(out_valid), 64'(0));
                check("async_rst_empty", 64'(empty), 64'(4'b1111));
                check("async_rst_ready", 64'(in_ready), 64'(4'b1111));
                check("async_rst_data", 64'(out_data), 64'(0));
                model_reset();
                #1;
                reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
